fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the immediate extender.
- Holds the PC, issues word requests to instruction memory and buffers the in-order responses in a small queue.
- Presents one instruction per handshake to decode: full word, instr[31:7] as the extender's 25-bit input, and the 2-bit ImmSrc decoded from the opcode.
- Handles redirects (branch/jump) by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, queue entries and max outstanding requests (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address (= pc).
- imem_rsp_valid  in  1  response valid; responses return in request order; no backpressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  PC redirect pulse.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode consumes head.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  PC of head instruction.
- dec_imm_field  out  25  dec_instr[31:7], wired to extender inp.
- dec_imm_src  out  2  ImmSrc for extender.

Behaviour:
- Reset is asynchronous active-low, as decided: one clock; reset is asynchronous and active-low.
  - Reset values: pc=RESET_PC, queue empty, inflight=0, discard=0, imem_req_valid=0, dec_valid=0.
  - dec_instr, dec_pc, dec_imm_field and dec_imm_src are 0 while the queue is empty.
  - Reset mid-operation drops everything; responses to pre-reset requests are the memory's responsibility.
- Issue rule:
  - imem_req_valid = (inflight + count < DEPTH) && !redirect_valid, registered-state based, asserted the first cycle after reset release.
  - On req_valid && req_ready: inflight++, pc += 4. pc wraps 32'hFFFF_FFFC -> 0.
- Response:
  - On rsp_valid: inflight--.
  - If discard > 0, discard-- and the data is dropped.
  - Otherwise push {data, pc_tag} into the queue. pc_tag comes from an in-order tag FIFO of issued addresses (DEPTH entries).
  - The issue rule guarantees the queue never overflows. Overflow is an assertion failure.
- Decode side:
  - dec_valid = count != 0.
  - Pop on dec_valid && dec_ready.
  - Min latency: response at edge N gives dec_valid high in cycle N+1.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (highest priority):
  - Queue and tag FIFO flushed; count=0.
  - discard = inflight minus 1 if a response arrives that same cycle (that response is dropped).
  - pc = {redirect_pc[31:2],2'b00}; no request in the redirect cycle.
  - A pop in the same cycle is void.
  - Back-to-back redirects: the last one wins; discard is recomputed from the current inflight.
- ImmSrc decode on dec_instr[6:0]:
  - 0000011 load, 0010011 op-imm, 1100111 jalr -> 00.
  - 0100011 store -> 01.
  - 1100011 branch -> 10.
  - 1101111 jal -> 11.
  - All others -> 00.
- Counter widths: inflight, count and discard are $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package (fetch_pkg): opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL; ImmSrc constants IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11. The extender uses the same constants.
- One sub-module, sync_fifo (parameterised width/depth, with flush, count output), instantiated twice: one for the instruction+pc queue, one for the address tags. ImmSrc decode is a combinational function in the package.

Test Plan:
- Reset release, memory always ready, 1-cycle response returning 32'h00A5_0283 (lw), dec_ready=1 -> addresses 0,4,8...; first dec_valid with dec_pc=0, dec_imm_src=00, dec_imm_field=25'h0014A05.
- Store word 32'hFE11_2E23 at pc 4 -> dec_imm_src=01, dec_imm_field=instr[31:7]. Branch 32'hFE00_0EE3 -> 10. JAL 32'h0080_006F -> 11.
- dec_ready=0 with DEPTH=2 -> exactly 2 requests issued, req_valid low until a pop, then exactly one new request per pop; no instruction lost or duplicated.
- Two requests in flight (addr 8,12), redirect to 32'h0000_0103 -> next request address 32'h100; the two stale responses are dropped; first dec_pc=32'h100.
- Redirect in the same cycle as a response and a dec pop -> response dropped, pop ignored, discard = inflight-1, queue empty next cycle.
- RESET_PC=32'hFFFF_FFF8, free-running -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Async rst_n asserted mid-stream -> req_valid and dec_valid low immediately, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode/ImmSrc constants, queue entry type and ImmSrc decode shared with the immediate extender.
package fetch_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic [1:0] imm_src(input logic [6:0] opc);
        return (opc == OPC_LOAD || opc == OPC_OPIMM || opc == OPC_JALR) ? IMM_I :
               (opc == OPC_STORE)  ? IMM_S :
               (opc == OPC_BRANCH) ? IMM_B :
               (opc == OPC_JAL)    ? IMM_J :
               IMM_I;
    endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect and decode handshake signals of the fetch front end.
interface fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [24:0] dec_imm_field;
    logic [1:0]  dec_imm_src;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_imm_field, dec_imm_src,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_imm_field, dec_imm_src,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and occupancy count; head is read combinationally.
module sync_fifo #(
    parameter int W = 32,
    parameter int D = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [W-1:0]        i_data,
    output logic [W-1:0]        o_data,
    output logic [$clog2(D):0]  o_count
);
    localparam int AW = $clog2(D);
    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;

    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;

    always_ff @(posedge clk)
        if (i_push && !i_flush) r_mem[r_wp] <= i_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(i_push);
            r_rp  <= r_rp + AW'(i_pop);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_flush && r_cnt == (AW+1)'(D)));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC/issue control, in-order response queue and ImmSrc decode feeding the immediate extender.
module fetch_queue import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master fq
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]   r_pc, w_tag;
    logic [CW-1:0] r_inflight, r_discard, w_count, w_tag_count;
    logic [CW:0]   w_occ;
    logic          w_redir, w_fire, w_rsp, w_keep, w_pop;
    fq_entry_t     w_head;

    assign w_redir = fq.redirect_valid;
    assign w_occ   = {1'b0, r_inflight} + {1'b0, w_count};
    assign fq.imem_req_valid = rst_n && !w_redir && (w_occ < (CW+1)'(DEPTH));
    assign fq.imem_req_addr  = r_pc;
    assign w_fire = fq.imem_req_valid && fq.imem_req_ready;
    assign w_rsp  = fq.imem_rsp_valid;
    // responses still owed to a pre-redirect PC are swallowed until r_discard drains
    assign w_keep = w_rsp && r_discard == '0 && !w_redir;
    assign fq.dec_valid     = w_count != '0;
    assign w_pop            = fq.dec_valid && fq.dec_ready && !w_redir;
    assign fq.dec_instr     = fq.dec_valid ? w_head.instr : '0;
    assign fq.dec_pc        = fq.dec_valid ? w_head.pc : '0;
    assign fq.dec_imm_field = fq.dec_instr[31:7];
    assign fq.dec_imm_src   = imm_src(fq.dec_instr[6:0]);

    sync_fifo #(.W($bits(fq_entry_t)), .D(DEPTH)) u_queue (
        .clk(clk), .rst_n(rst_n), .i_flush(w_redir), .i_push(w_keep), .i_pop(w_pop),
        .i_data({fq.imem_rsp_data, w_tag}), .o_data(w_head), .o_count(w_count)
    );

    sync_fifo #(.W(32), .D(DEPTH)) u_tags (
        .clk(clk), .rst_n(rst_n), .i_flush(w_redir), .i_push(w_fire), .i_pop(w_keep),
        .i_data(r_pc), .o_data(w_tag), .o_count(w_tag_count)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_fire) - CW'(w_rsp);
            r_discard  <= w_redir ? r_inflight - CW'(w_rsp) : r_discard - CW'(w_rsp && r_discard != '0);
            r_pc       <= w_redir ? (fq.redirect_pc & ~32'h3) : r_pc + (w_fire ? 32'd4 : 32'd0);
        end

    // every outstanding request is either tagged for the queue or marked for discard
    a_tag_balance: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, w_tag_count} + {1'b0, r_discard}) == {1'b0, r_inflight});
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench with an in-order latency memory model; second instance covers RESET_PC wrap.
module tb_fetch_queue;
    localparam int DEPTH = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if fq ();
    fetch_queue_if fq2 ();
    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (.clk(clk), .rst_n(rst_n), .fq(fq));
    fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut2 (.clk(clk), .rst_n(rst_n), .fq(fq2));

    typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
    typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
    req_t pend[$];
    exp_t sb[$];
    int n_tests = 0, n_fail = 0, n_req = 0, cyc_n = 0, lat = 1, rsp_now = 0, kept_now = 0, q2n = 0;
    logic [31:0] exp_pc = 32'h0, first_pc = 32'hDEAD_BEEF;
    logic [31:0] a2 [3];
    logic want_first = 1'b0, fire2 = 1'b0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [1:0] ref_src(input logic [31:0] w);
        case (w[6:0])
            7'h23:   return 2'b01;
            7'h63:   return 2'b10;
            7'h6F:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc [8];
        opc = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h37};
        case (a)
            32'd0:   return 32'h00A5_0283;
            32'd4:   return 32'hFE11_2E23;
            32'd8:   return 32'hFE00_0EE3;
            32'd12:  return 32'h0080_006F;
            default: return {a[26:2], opc[a[4:2]]};
        endcase
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (pend[i]) n += pend[i].stale ? 0 : 1;
        return n;
    endfunction

    function automatic logic [31:0] first_live_addr();
        foreach (pend[i]) if (!pend[i].stale) return pend[i].addr;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        int   occ;
        exp_t e;
        req_t r;
        @(negedge clk);
        occ = pend.size() + rsp_now + sb.size() - kept_now;
        check("req_valid", fq.imem_req_valid, (occ < DEPTH) && !fq.redirect_valid);
        check("dec_valid", fq.dec_valid, (sb.size() - kept_now) != 0);
        if (!fq.dec_valid)
            check("idle_zero", {fq.dec_instr, fq.dec_pc, fq.dec_imm_field, fq.dec_imm_src}, 96'h0);
        if (fq.imem_req_valid && fq.imem_req_ready) begin
            check("req_addr", fq.imem_req_addr, exp_pc);
            pend.push_back('{fq.imem_req_addr, cyc_n + lat, 1'b0});
            exp_pc += 32'd4;
            n_req++;
        end
        if (fq.redirect_valid) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            sb.delete();
            exp_pc = fq.redirect_pc & ~32'h3;
        end else if (fq.dec_valid && fq.dec_ready && sb.size() > kept_now) begin
            e = sb.pop_front();
            check("dec_pc", fq.dec_pc, e.pc);
            check("dec_instr", fq.dec_instr, e.instr);
            check("imm_field", fq.dec_imm_field, e.instr >> 7);
            check("imm_src", fq.dec_imm_src, ref_src(e.instr));
            if (e.pc == 32'h0 && e.instr == 32'h00A5_0283) check("lw_field", fq.dec_imm_field, 25'h0014A05);
            if (want_first) begin
                first_pc = e.pc;
                want_first = 1'b0;
            end
        end
        if (fq2.imem_req_valid && q2n < 3) begin
            a2[q2n] = fq2.imem_req_addr;
            q2n++;
        end
        fire2 = fq2.imem_req_valid;
        @(posedge clk);
        #1;
        cyc_n++;
        fq2.imem_rsp_valid = fire2;
        rsp_now = 0;
        kept_now = 0;
        fq.imem_rsp_valid = 1'b0;
        fq.imem_rsp_data = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc_n) begin
            r = pend.pop_front();
            fq.imem_rsp_valid = 1'b1;
            fq.imem_rsp_data = mem_word(r.addr);
            rsp_now = 1;
            if (!r.stale) begin
                sb.push_back('{mem_word(r.addr), r.addr});
                kept_now = 1;
            end
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = target;
        tick();
        fq.redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fq.imem_req_ready = 1'b0; fq.imem_rsp_valid = 1'b0; fq.imem_rsp_data = 32'h0;
        fq.redirect_valid = 1'b0; fq.redirect_pc = 32'h0; fq.dec_ready = 1'b0;
        fq2.imem_req_ready = 1'b1; fq2.imem_rsp_valid = 1'b0; fq2.imem_rsp_data = 32'h0000_0013;
        fq2.redirect_valid = 1'b0; fq2.redirect_pc = 32'h0; fq2.dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_valid", fq.imem_req_valid, 1'b0);
        check("rst_dec_valid", fq.dec_valid, 1'b0);
        check("rst_addr", fq.imem_req_addr, 32'h0);
        check("rst_dec_zero", {fq.dec_instr, fq.dec_pc}, 64'h0);
        check("rst2_addr", fq2.imem_req_addr, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fq.imem_req_ready = 1'b1;
        fq.dec_ready = 1'b1;
        repeat (12) tick();
        check("wrap2_a0", a2[0], 32'hFFFF_FFF8);
        check("wrap2_a1", a2[1], 32'hFFFF_FFFC);
        check("wrap2_a2", a2[2], 32'h0000_0000);

        begin
            int n0;
            fq.dec_ready = 1'b0;
            repeat (6) tick();
            n0 = n_req;
            repeat (6) tick();
            check("stall_no_req", n_req - n0, 0);
            fq.dec_ready = 1'b1;
            tick();
            fq.dec_ready = 1'b0;
            n0 = n_req;
            repeat (6) tick();
            check("one_req_per_pop", n_req - n0, 1);
        end

        fq.dec_ready = 1'b1;
        lat = 3;
        redirect(32'h0000_0008);
        for (int k = 0; k < 30 && live_cnt() < 2; k++) tick();
        check("two_inflight", live_cnt(), 2);
        check("inflight_addr", first_live_addr(), 32'h8);
        want_first = 1'b1;
        redirect(32'h0000_0103);
        for (int k = 0; k < 30 && want_first; k++) tick();
        check("redir_first_pc", first_pc, 32'h100);

        lat = 1;
        repeat (6) tick();
        fq.dec_ready = 1'b0;
        for (int k = 0; k < 20 && !(rsp_now == 1 && fq.dec_valid); k++) tick();
        check("rsp_pop_setup", (rsp_now == 1) && fq.dec_valid, 1'b1);
        fq.dec_ready = 1'b1;
        redirect(32'h0000_0040);
        check("flush_empty", fq.dec_valid, 1'b0);
        repeat (10) tick();

        redirect(32'hFFFF_FFF8);
        repeat (10) tick();

        fq.dec_ready = 1'b0;
        repeat (3) tick();
        check("pre_rst_dec_valid", fq.dec_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_valid", fq.imem_req_valid, 1'b0);
        check("async_dec_valid", fq.dec_valid, 1'b0);
        check("async_pc", fq.imem_req_addr, 32'h0);
        check("async_pc2", fq2.imem_req_addr, 32'hFFFF_FFF8);
        pend.delete();
        sb.delete();
        rsp_now = 0;
        kept_now = 0;
        exp_pc = 32'h0;
        fq.imem_rsp_valid = 1'b0;
        fq2.imem_rsp_valid = 1'b0;
        fire2 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fq.dec_ready = 1'b1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
